// File: rtl/i2s_pkg.sv
// ---------------------------------------------------------------------------
// i2s_pkg
// Shared definitions for the multichannel I2S capture / AXI-Stream packer:
//   - seq_state_e : push sequencer states (IDLE / CAPTURE / PUSH)
//   - DROP_CNT_W  : width of the saturating dropped-frame counter
//   - calc_beats  : number of AXIS beats needed for one packed frame
//   - params_ok   : parameter legality check used at elaboration time
// ---------------------------------------------------------------------------
package i2s_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE    = 2'd0,
        SEQ_CAPTURE = 2'd1,
        SEQ_PUSH    = 2'd2
    } seq_state_e;

    localparam int DROP_CNT_W = 16;

    function automatic int calc_beats(input int num_ch, input int slot_w, input int axis_w);
        return (num_ch * slot_w) / axis_w;
    endfunction

    // Legal parameter set: a frame splits into whole beats, the FIFO can hold
    // a complete frame, samples fit their slots, and the data delay is 0 or 1.
    function automatic bit params_ok(input int num_ch, input int sample_w, input int slot_w,
                                     input int axis_w, input int fifo_depth,
                                     input int data_delay);
        return (num_ch >= 1) && (sample_w >= 2) && (slot_w >= sample_w) && (axis_w >= 1) &&
               (((num_ch * slot_w) % axis_w) == 0) &&
               (calc_beats(num_ch, slot_w, axis_w) >= 1) &&
               (fifo_depth >= calc_beats(num_ch, slot_w, axis_w)) &&
               ((data_delay == 0) || (data_delay == 1));
    endfunction

endpackage

// File: rtl/axis_beat_fifo.sv
// ---------------------------------------------------------------------------
// axis_beat_fifo
// First-word-fall-through FIFO for stream beats. The head entry is always
// presented on pop_data_o while valid_o is high; pointers wrap modulo DEPTH,
// so DEPTH need not be a power of two.
//
// Ports:
//   clk_i        clock (rising edge)
//   rst_i        asynchronous active-high reset, empties the FIFO
//   push_i       write push_data_i (ignored when full)
//   push_data_i  entry to write
//   pop_i        remove head entry (ignored when empty)
//   pop_data_o   head entry
//   valid_o      FIFO not empty
//   level_o      current number of stored entries
//
// A simultaneous push and pop both take effect and leave the level unchanged.
// ---------------------------------------------------------------------------
module axis_beat_fifo #(
    parameter int WIDTH = 129,
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             valid_o,
    output logic [LVL_W-1:0] level_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && (level_q != LVL_W'(DEPTH));
    assign do_pop  = pop_i && (level_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= next_ptr(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign valid_o    = (level_q != '0);
    assign level_o    = level_q;

endmodule

// File: rtl/i2s_multich_axis_packer.sv
// ---------------------------------------------------------------------------
// i2s_multich_axis_packer
// Captures NUM_CH I2S-style serial lines sharing sck/ws, extends each sample
// to a SLOT_W slot, packs one frame (all channels) into AXIS_W-wide beats and
// queues them in a beat FIFO. A frame that does not fit as a whole is dropped
// and counted. Everything runs on the rising edge of sck.
//
// Ports:
//   sck            bit clock
//   rst            asynchronous active-high reset
//   start          capture enable
//   ws             word select / frame sync
//   sd             serial data, bit i = channel i
//   m_axis_tdata   packed slots (channel c at frame bits [c*SLOT_W +: SLOT_W])
//   m_axis_tvalid  beat valid
//   m_axis_tlast   last beat of a frame
//   m_axis_tready  sink ready
//   overflow       one-cycle pulse per dropped frame
//   short_frame    one-cycle pulse when the active phase ends early
//   drop_count     saturating dropped-frame count
//   fifo_level     beat FIFO occupancy
//   dbg_state      push sequencer state (seq_state_e encoding)
//
// Stream handshake: a beat transfers on a rising sck edge where
// m_axis_tvalid && m_axis_tready; once tvalid is high it stays high, and
// tdata/tlast hold their values, until that transfer happens.
// ---------------------------------------------------------------------------
module i2s_multich_axis_packer
    import i2s_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int SAMPLE_W   = 24,
    parameter int SLOT_W     = 32,
    parameter int AXIS_W     = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int ACTIVE_WS  = 0,
    parameter int DATA_DELAY = 1,
    parameter int SIGN_EXT   = 1
) (
    input  logic                             sck,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             ws,
    input  logic [NUM_CH-1:0]                sd,
    output logic [AXIS_W-1:0]                m_axis_tdata,
    output logic                             m_axis_tvalid,
    output logic                             m_axis_tlast,
    input  logic                             m_axis_tready,
    output logic                             overflow,
    output logic                             short_frame,
    output logic [DROP_CNT_W-1:0]            drop_count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic [1:0]                       dbg_state
);

    localparam int   BEATS   = calc_beats(NUM_CH, SLOT_W, AXIS_W);
    localparam int   FRAME_W = NUM_CH * SLOT_W;
    localparam int   LVL_W   = $clog2(FIFO_DEPTH + 1);
    localparam int   LAST_K  = DATA_DELAY + SAMPLE_W - 1;
    localparam int   CNT_W   = $clog2(LAST_K + 2);
    localparam int   BIDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic ACT_LVL = 1'(ACTIVE_WS);

    if (!params_ok(NUM_CH, SAMPLE_W, SLOT_W, AXIS_W, FIFO_DEPTH, DATA_DELAY)) begin : g_bad_params
        $error("i2s_multich_axis_packer: illegal parameter combination");
    end

    seq_state_e                       state_q, state_d;
    logic                             ws_q;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]  shift_q, shift_d, shift_nxt;
    logic [BIDX_W-1:0]                bidx_q, bidx_d;
    logic                             overflow_q, overflow_d;
    logic                             short_q, short_d;
    logic [DROP_CNT_W-1:0]            drop_q, drop_d;

    logic                             ws_active;
    logic                             phase_start;
    logic                             free_ok;
    logic                             push_en;
    logic [AXIS_W:0]                  push_data;
    logic [FRAME_W-1:0]               frame;
    logic [AXIS_W:0]                  fifo_head;
    logic [LVL_W-1:0]                 level_w;
    logic                             fifo_valid;

    assign ws_active   = (ws == ACT_LVL);
    assign phase_start = start && ws_active && (ws_q != ACT_LVL);
    // Free space is judged on the level before this edge's pop.
    assign free_ok     = (level_w <= LVL_W'(FIFO_DEPTH - BEATS));

    always_comb begin
        shift_nxt = shift_q;
        for (int c = 0; c < NUM_CH; c++) begin
            shift_nxt[c] = {shift_q[c][SAMPLE_W-2:0], sd[c]};
        end
    end

    // The shift registers hold still outside CAPTURE, so they serve as the
    // frame register while the beats are written.
    always_comb begin
        frame = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int b = 0; b < SAMPLE_W; b++) begin
                frame[c*SLOT_W + b] = shift_q[c][b];
            end
            for (int b = SAMPLE_W; b < SLOT_W; b++) begin
                frame[c*SLOT_W + b] = (SIGN_EXT != 0) && shift_q[c][SAMPLE_W-1];
            end
        end
    end

    assign push_data = {(bidx_q == BIDX_W'(BEATS - 1)), frame[bidx_q*AXIS_W +: AXIS_W]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        bidx_d     = bidx_q;
        overflow_d = 1'b0;
        short_d    = 1'b0;
        drop_d     = drop_q;
        push_en    = 1'b0;
        case (state_q)
            SEQ_IDLE: begin
                if (phase_start) begin
                    state_d = SEQ_CAPTURE;
                    cnt_d   = CNT_W'(1);
                    if (DATA_DELAY == 0) begin
                        shift_d = shift_nxt;
                    end
                end
            end
            SEQ_CAPTURE: begin
                // cnt_q is the edge index k; from k=1 onward every edge up to
                // LAST_K lies inside the capture window.
                if (!start) begin
                    state_d = SEQ_IDLE;
                    cnt_d   = '0;
                end else if (!ws_active) begin
                    state_d = SEQ_IDLE;
                    cnt_d   = '0;
                    short_d = 1'b1;
                end else begin
                    shift_d = shift_nxt;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(LAST_K)) begin
                        state_d = SEQ_PUSH;
                        cnt_d   = '0;
                        bidx_d  = '0;
                    end
                end
            end
            SEQ_PUSH: begin
                if ((bidx_q == '0) && !free_ok) begin
                    overflow_d = 1'b1;
                    state_d    = SEQ_IDLE;
                    if (drop_q != '1) begin
                        drop_d = drop_q + 1'b1;
                    end
                end else begin
                    push_en = 1'b1;
                    if (bidx_q == BIDX_W'(BEATS - 1)) begin
                        state_d = SEQ_IDLE;
                        bidx_d  = '0;
                    end else begin
                        bidx_d = bidx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = SEQ_IDLE;
            end
        endcase
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state_q    <= SEQ_IDLE;
            ws_q       <= ~ACT_LVL;
            cnt_q      <= '0;
            shift_q    <= '0;
            bidx_q     <= '0;
            overflow_q <= 1'b0;
            short_q    <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            ws_q       <= ws;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bidx_q     <= bidx_d;
            overflow_q <= overflow_d;
            short_q    <= short_d;
            drop_q     <= drop_d;
        end
    end

    axis_beat_fifo #(
        .WIDTH (AXIS_W + 1),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk_i       (sck),
        .rst_i       (rst),
        .push_i      (push_en),
        .push_data_i (push_data),
        .pop_i       (m_axis_tvalid && m_axis_tready),
        .pop_data_o  (fifo_head),
        .valid_o     (fifo_valid),
        .level_o     (level_w)
    );

    assign m_axis_tdata  = fifo_head[AXIS_W-1:0];
    assign m_axis_tlast  = fifo_head[AXIS_W];
    assign m_axis_tvalid = fifo_valid;
    assign overflow      = overflow_q;
    assign short_frame   = short_q;
    assign drop_count    = drop_q;
    assign fifo_level    = level_w;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_i2s_multich_axis_packer.sv
module tb_i2s_multich_axis_packer;

  localparam int NUM_CH     = 8;
  localparam int SAMPLE_W   = 24;
  localparam int SLOT_W     = 32;
  localparam int AXIS_W     = 128;
  localparam int FIFO_DEPTH = 4;
  localparam int BEATS      = NUM_CH * SLOT_W / AXIS_W;
  localparam int FRAME_W    = NUM_CH * SLOT_W;
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);

  typedef logic [AXIS_W:0] beat_t;

  // ---------------- clock / reset / DUT ----------------
  logic              sck = 1'b0;
  logic              rst;
  logic              start;
  logic              ws;
  logic [NUM_CH-1:0] sd;
  logic              tready;

  logic [AXIS_W-1:0] tdata, z_tdata;
  logic              tvalid, z_tvalid, tlast, z_tlast;
  logic              overflow, z_overflow, short_frame, z_short_frame;
  logic [15:0]       drop_count, z_drop_count;
  logic [LVL_W-1:0]  fifo_level, z_fifo_level;
  logic [1:0]        dbg_state, z_dbg_state;

  always #5 sck = ~sck;

  i2s_multich_axis_packer #(.SIGN_EXT(1)) dut (
    .sck(sck), .rst(rst), .start(start), .ws(ws), .sd(sd),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
    .m_axis_tready(tready), .overflow(overflow), .short_frame(short_frame),
    .drop_count(drop_count), .fifo_level(fifo_level), .dbg_state(dbg_state)
  );

  i2s_multich_axis_packer #(.SIGN_EXT(0)) dut_z (
    .sck(sck), .rst(rst), .start(start), .ws(ws), .sd(sd),
    .m_axis_tdata(z_tdata), .m_axis_tvalid(z_tvalid), .m_axis_tlast(z_tlast),
    .m_axis_tready(tready), .overflow(z_overflow), .short_frame(z_short_frame),
    .drop_count(z_drop_count), .fifo_level(z_fifo_level), .dbg_state(z_dbg_state)
  );

  // ---------------- scoreboard state ----------------
  beat_t exp_q[$];
  beat_t expz_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int model_level = 0;
  int exp_ovf = 0, ovf_seen = 0;
  int exp_short = 0, short_seen = 0;
  int exp_drops = 0;
  logic [SAMPLE_W-1:0] samp [NUM_CH];
  bit chk_spacing = 0;
  int last_tlast = -1;
  bit chk_lat = 0;
  bit lat_armed = 0;
  int lat_exp = 0;
  bit rnd_ready = 0;
  bit prev_hold = 0;
  bit prev_v = 0;
  beat_t prev_beat;

  always @(posedge sck) cyc <= cyc + 1;

  task automatic check(input string name, input logic [AXIS_W:0] act, input logic [AXIS_W:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is the concatenation of per-channel slots; each slot is the
  // sample value, widened with ones above bit SAMPLE_W-1 when sign-extending
  // a negative sample.
  function automatic logic [FRAME_W-1:0] model_frame(input bit sext);
    logic [FRAME_W-1:0] f;
    logic [SLOT_W-1:0]  slot;
    f = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      slot = SLOT_W'(samp[c]);
      if (sext && samp[c][SAMPLE_W-1]) slot = slot | ({SLOT_W{1'b1}} << SAMPLE_W);
      f = f | (FRAME_W'(slot) << (c * SLOT_W));
    end
    return f;
  endfunction

  task automatic predict_frame();
    logic [FRAME_W-1:0] fs, fz;
    if (model_level <= FIFO_DEPTH - BEATS) begin
      fs = model_frame(1'b1);
      fz = model_frame(1'b0);
      if (chk_lat && model_level == 0) begin
        lat_armed = 1;
        lat_exp   = cyc + 2;
      end
      for (int b = 0; b < BEATS; b++) begin
        exp_q.push_back({(b == BEATS - 1), fs[b*AXIS_W +: AXIS_W]});
        expz_q.push_back({(b == BEATS - 1), fz[b*AXIS_W +: AXIS_W]});
      end
      model_level += BEATS;
    end else begin
      exp_ovf++;
      if (exp_drops < 65535) exp_drops++;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge sck) begin
    if (rst) begin
      prev_hold = 0;
      prev_v    = 0;
    end else begin
      if (prev_hold) begin
        check("hold_tvalid", tvalid, 1);
        check("hold_beat", {tlast, tdata}, prev_beat);
      end
      if (lat_armed && tvalid && !prev_v) begin
        check("latency_cycle", cyc, lat_exp);
        lat_armed = 0;
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got %h expected none", {tlast, tdata});
        end else begin
          check("beat", {tlast, tdata}, exp_q.pop_front());
        end
        model_level--;
        if (tlast && chk_spacing) begin
          if (last_tlast >= 0) check("frame_spacing", cyc - last_tlast, 128);
          last_tlast = cyc;
        end
      end
      if (z_tvalid && tready) begin
        if (expz_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_zbeat: got %h expected none", {z_tlast, z_tdata});
        end else begin
          check("zext_beat", {z_tlast, z_tdata}, expz_q.pop_front());
        end
      end
      prev_hold = tvalid && !tready;
      prev_v    = tvalid;
      prev_beat = {tlast, tdata};
      if (overflow) ovf_seen++;
      if (short_frame) short_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sck);
    #1;
  endtask

  task automatic rand_samples();
    for (int c = 0; c < NUM_CH; c++) samp[c] = SAMPLE_W'($urandom);
  endtask

  // One 128-sck frame: ws active (low) for act_len cycles, then high.
  // Bits 1..SAMPLE_W after the phase-start edge carry the samples MSB first.
  task automatic run_phase(input int act_len, input int bp_at, input int bp_len);
    bit cap;
    cap = start;
    for (int j = 0; j < 128; j++) begin
      tick();
      ws = (j < act_len) ? 1'b0 : 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (j >= 1 && j <= SAMPLE_W && j < act_len) sd[c] = samp[c][SAMPLE_W - j];
        else sd[c] = 1'($urandom_range(0, 1));
      end
      if (bp_at >= 0) tready = !(j >= bp_at && j < bp_at + bp_len);
      else if (rnd_ready) tready = 1'($urandom_range(0, 1));
      if (cap && j == act_len && act_len <= SAMPLE_W) exp_short++;
      if (cap && j == SAMPLE_W && act_len > SAMPLE_W) predict_frame();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      ws = 1'b1;
      sd = NUM_CH'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge sck);
    check({tag, "_tvalid"}, tvalid, 0);
    check({tag, "_tdata"}, tdata, 0);
    check({tag, "_tlast"}, tlast, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_short"}, short_frame, 0);
    check({tag, "_drop_count"}, drop_count, 0);
    check({tag, "_fifo_level"}, fifo_level, 0);
    check({tag, "_z_tvalid"}, z_tvalid, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b1; ws = 1'b1; sd = '0; tready = 1'b1;
    repeat (3) @(posedge sck);
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;
    idle(5);

    // Basic capture, fixed pattern, tready high
    samp[0] = 24'haaaaaa; samp[1] = 24'hbbbbbb; samp[2] = 24'hcccccc; samp[3] = 24'hdddddd;
    samp[4] = 24'heeeeee; samp[5] = 24'hffffff; samp[6] = 24'h111111; samp[7] = 24'h222222;
    chk_spacing = 1; chk_lat = 1; last_tlast = -1;
    repeat (3) run_phase(64, -1, 0);
    chk_spacing = 0; chk_lat = 0;

    // Brief backpressure spanning the push
    rand_samples();
    run_phase(64, 20, 20);
    check("bp_no_overflow", ovf_seen, exp_ovf);

    // Short active phase, then a normal frame
    rand_samples();
    run_phase(10, -1, 0);
    rand_samples();
    run_phase(64, -1, 0);
    check("short_count", short_seen, exp_short);

    // Sustained backpressure across 4 frames
    tick();
    tready = 1'b0;
    for (int f = 0; f < 4; f++) begin
      rand_samples();
      run_phase(64, -1, 0);
    end
    @(negedge sck);
    check("sustained_overflows", ovf_seen, exp_ovf);
    check("sustained_drop_count", drop_count, exp_drops);
    check("sustained_level", fifo_level, FIFO_DEPTH);
    tick();
    tready = 1'b1;
    idle(10);
    check("sustained_drained", exp_q.size(), 0);

    // start low for one phase: skipped, next captured
    start = 1'b0;
    rand_samples();
    run_phase(64, -1, 0);
    start = 1'b1;
    rand_samples();
    run_phase(64, -1, 0);

    // Reset mid-capture with 3 beats queued
    tready = 1'b0;
    for (int f = 0; f < 2; f++) begin
      rand_samples();
      run_phase(64, -1, 0);
    end
    tick();
    tready = 1'b1;
    tick();
    tready = 1'b0;
    @(negedge sck);
    check("pre_reset_level", fifo_level, 3);
    rand_samples();
    for (int j = 0; j < 13; j++) begin
      tick();
      ws = 1'b0;
      sd = NUM_CH'($urandom);
    end
    tick();
    rst = 1'b1;
    check_reset_outputs("midcap_reset");
    exp_q.delete();
    expz_q.delete();
    model_level = 0;
    exp_drops = 0;
    ws = 1'b1;
    tready = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(70);

    // Randomized frames with random sink readiness
    rnd_ready = 1;
    for (int f = 0; f < 6; f++) begin
      rand_samples();
      run_phase(64, -1, 0);
    end
    rnd_ready = 0;
    tick();
    tready = 1'b1;

    // Bounded drain
    for (int i = 0; i < 300 && (exp_q.size() != 0 || expz_q.size() != 0); i++) tick();
    @(negedge sck);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_zqueue_empty", expz_q.size(), 0);
    check("final_overflows", ovf_seen, exp_ovf);
    check("final_short", short_seen, exp_short);
    check("final_drop_count", drop_count, exp_drops);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
